// File: rtl/guess_game_if.sv
// Button/enter inputs and game-status outputs of the number-guessing controller.
// The master side presses buttons; the slave side (the controller) reports results.
interface guess_game_if;
    logic       I1;
    logic       I2;
    logic       I3;
    logic       I4;
    logic       enter;
    logic       win;
    logic       lose;
    logic       equal;
    logic       bigger;
    logic       smaller;
    logic [3:0] nums;

    modport master (
        output I1, I2, I3, I4, enter,
        input  win, lose, equal, bigger, smaller, nums
    );

    modport slave (
        input  I1, I2, I3, I4, enter,
        output win, lose, equal, bigger, smaller, nums
    );
endinterface

// File: rtl/guess_game_ctrl.sv
// Number-guessing game: type a secret with digit buttons 1..4, then guess it.
// Each guess reports equal/bigger/smaller; win or lose is sticky until reset.
module guess_game_ctrl #(
    parameter int MAX_TRIES  = 4,
    parameter int MAX_DIGITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    guess_game_if.slave   bus
);

    localparam int BW = 2 * MAX_DIGITS;
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        S_SECRET = 2'd0,
        S_GUESS  = 2'd1,
        S_WIN    = 2'd2,
        S_LOSE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_prev;
    logic            r_armed;
    logic [BW-1:0]   r_buf;
    logic [3:0]      r_nums;
    logic [BW-1:0]   r_secret;
    logic [3:0]      r_slen;
    logic [TW-1:0]   r_tries;
    logic            r_win;
    logic            r_lose;
    logic            r_equal;
    logic            r_bigger;
    logic            r_smaller;

    state_t          w_state_nxt;
    logic [BW-1:0]   w_buf_nxt;
    logic [3:0]      w_nums_nxt;
    logic [BW-1:0]   w_secret_nxt;
    logic [3:0]      w_slen_nxt;
    logic [TW-1:0]   w_tries_nxt;
    logic            w_win_nxt;
    logic            w_lose_nxt;
    logic            w_equal_nxt;
    logic            w_bigger_nxt;
    logic            w_smaller_nxt;

    logic [4:0]      w_cur;
    logic [4:0]      w_evt;
    logic [3:0]      w_dig;
    logic            w_ent;
    logic            w_single;
    logic [1:0]      w_code;
    logic            w_eq;
    logic            w_gt;
    logic [TW-1:0]   w_tries_inc;
    logic [BW-1:0]   w_buf_app;

    // r_armed keeps the first cycle after reset from seeing a held button as a rising edge.
    assign w_cur       = {bus.enter, bus.I4, bus.I3, bus.I2, bus.I1};
    assign w_evt       = w_cur & ~r_prev & {5{r_armed}};
    assign w_dig       = w_evt[3:0];
    assign w_ent       = w_evt[4];
    assign w_single    = (w_dig != 4'd0) && ((w_dig & (w_dig - 4'd1)) == 4'd0);
    assign w_tries_inc = r_tries + TW'(1);
    assign w_buf_app   = (r_buf << 2) | BW'(w_code);

    // Unused high buffer bits stay zero, so equal-length entries compare as plain numbers.
    assign w_eq = (r_nums == r_slen) && (r_buf == r_secret);
    assign w_gt = (r_nums > r_slen) || ((r_nums == r_slen) && (r_buf > r_secret));

    // One-hot digit event to its 2-bit code (value minus one).
    always_comb begin
        w_code = 2'd0;
        case (w_dig)
            4'b0001: w_code = 2'd0;
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    // Next-state and next-datapath logic of the game FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_nums_nxt    = r_nums;
        w_secret_nxt  = r_secret;
        w_slen_nxt    = r_slen;
        w_tries_nxt   = r_tries;
        w_win_nxt     = r_win;
        w_lose_nxt    = r_lose;
        w_equal_nxt   = r_equal;
        w_bigger_nxt  = r_bigger;
        w_smaller_nxt = r_smaller;
        case (r_state)
            S_SECRET, S_GUESS: begin
                if (w_ent) begin
                    // An enter edge always drops any simultaneous digit.
                    if (r_nums != 4'd0) begin
                        w_buf_nxt  = '0;
                        w_nums_nxt = 4'd0;
                        if (r_state == S_SECRET) begin
                            w_secret_nxt = r_buf;
                            w_slen_nxt   = r_nums;
                            w_state_nxt  = S_GUESS;
                        end else begin
                            w_tries_nxt   = w_tries_inc;
                            w_equal_nxt   = w_eq;
                            w_bigger_nxt  = w_gt;
                            w_smaller_nxt = !w_eq && !w_gt;
                            if (w_eq) begin
                                w_win_nxt   = 1'b1;
                                w_state_nxt = S_WIN;
                            end else if (w_tries_inc == TW'(MAX_TRIES)) begin
                                w_lose_nxt  = 1'b1;
                                w_state_nxt = S_LOSE;
                            end else begin
                                w_state_nxt = S_GUESS;
                            end
                        end
                    end else begin
                        w_nums_nxt = r_nums;
                    end
                end else if (w_single && (r_nums < 4'(MAX_DIGITS))) begin
                    w_buf_nxt  = w_buf_app;
                    w_nums_nxt = r_nums + 4'd1;
                end else begin
                    w_buf_nxt = r_buf;
                end
            end
            S_WIN, S_LOSE: begin
                w_nums_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = S_SECRET;
            end
        endcase
    end

    // State, datapath and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_SECRET;
            r_prev    <= 5'd0;
            r_armed   <= 1'b0;
            r_buf     <= '0;
            r_nums    <= 4'd0;
            r_secret  <= '0;
            r_slen    <= 4'd0;
            r_tries   <= '0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_equal   <= 1'b0;
            r_bigger  <= 1'b0;
            r_smaller <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_cur;
            r_armed   <= 1'b1;
            r_buf     <= w_buf_nxt;
            r_nums    <= w_nums_nxt;
            r_secret  <= w_secret_nxt;
            r_slen    <= w_slen_nxt;
            r_tries   <= w_tries_nxt;
            r_win     <= w_win_nxt;
            r_lose    <= w_lose_nxt;
            r_equal   <= w_equal_nxt;
            r_bigger  <= w_bigger_nxt;
            r_smaller <= w_smaller_nxt;
        end
    end

    assign bus.win     = r_win;
    assign bus.lose    = r_lose;
    assign bus.equal   = r_equal;
    assign bus.bigger  = r_bigger;
    assign bus.smaller = r_smaller;
    assign bus.nums    = r_nums;

endmodule
